// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq (with helper muldiv_au)
// Description : Multi-cycle MULT/MULTU/DIV/DIVU sequencer producing HI/LO,
//               built around one shared adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================

module muldiv_au #(
    parameter int WIDTH = 65
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] w_full;

    // sub=1 gives x - y as x + ~y + 1; cout=1 then means "no borrow".
    assign w_full = {1'b0, x} + {1'b0, y ^ {WIDTH{sub}}} + {{WIDTH{1'b0}}, sub};
    assign sum    = w_full[WIDTH-1:0];
    assign cout   = w_full[WIDTH];
endmodule

module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    localparam int c_au_w  = 2*WIDTH + 1;
    localparam int c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH-1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    // Guard bit between two WIDTH-bit fields lets one au pass negate both
    // fields independently: it absorbs the low carry and feeds a fixed +1 up.
    localparam logic [c_au_w-1:0]  c_guard    = {{WIDTH{1'b0}}, 1'b1, {WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_hi_w;     // accumulator / remainder
    logic [WIDTH-1:0]   r_lo_w;     // raw a, then multiplier / quotient
    logic [WIDTH-1:0]   r_opnd;     // raw b, then multiplicand / divisor
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_res_neg;
    logic               r_rem_neg;
    logic               r_dz_pend;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_div_zero;

    logic [c_au_w-1:0]  w_au_x;
    logic [c_au_w-1:0]  w_au_y;
    logic               w_au_sub;
    logic [c_au_w-1:0]  w_au_sum;
    logic               w_au_cout;

    logic               w_accept;
    logic               w_is_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH:0]     w_rem_shift;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    muldiv_au #(.WIDTH(c_au_w)) u_au (
        .x    (w_au_x),
        .y    (w_au_y),
        .sub  (w_au_sub),
        .sum  (w_au_sum),
        .cout (w_au_cout)
    );

    assign w_accept    = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && !flush;
    assign w_is_div    = r_op[1];
    assign w_a_neg     = r_op[0] & r_lo_w[WIDTH-1];
    assign w_b_neg     = r_op[0] & r_opnd[WIDTH-1];
    assign w_rem_shift = {r_hi_w, r_lo_w[WIDTH-1]};
    assign w_mag_a     = w_a_neg ? w_au_sum[2*WIDTH:WIDTH+1] : r_lo_w;
    assign w_mag_b     = w_b_neg ? w_au_sum[WIDTH-1:0]       : r_opnd;

    // Operand routing into the shared au for each phase.
    always_comb begin
        w_au_x   = '0;
        w_au_y   = '0;
        w_au_sub = 1'b0;
        case (r_state)
            S_PREP: begin
                w_au_x   = c_guard;
                w_au_y   = {(w_a_neg ? r_lo_w : {WIDTH{1'b0}}), 1'b0,
                            (w_b_neg ? r_opnd : {WIDTH{1'b0}})};
                w_au_sub = 1'b1;
            end
            S_ITER: begin
                if (w_is_div) begin
                    w_au_x   = {{WIDTH{1'b0}}, w_rem_shift};
                    w_au_y   = {{(WIDTH+1){1'b0}}, r_opnd};
                    w_au_sub = 1'b1;
                end else begin
                    w_au_x   = {{(WIDTH+1){1'b0}}, r_hi_w};
                    w_au_y   = {{(WIDTH+1){1'b0}}, (r_lo_w[0] ? r_opnd : {WIDTH{1'b0}})};
                end
            end
            S_FIX: begin
                w_au_sub = 1'b1;
                if (w_is_div) begin
                    w_au_x = c_guard;
                    w_au_y = {(r_rem_neg ? r_hi_w : {WIDTH{1'b0}}), 1'b0,
                              (r_res_neg ? r_lo_w : {WIDTH{1'b0}})};
                end else begin
                    w_au_y = {1'b0, r_hi_w, r_lo_w};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_fix_hi = r_hi_w;
        w_fix_lo = r_lo_w;
        if (w_is_div) begin
            if (r_rem_neg) w_fix_hi = w_au_sum[2*WIDTH:WIDTH+1];
            if (r_res_neg) w_fix_lo = w_au_sum[WIDTH-1:0];
        end else if (r_res_neg) begin
            w_fix_hi = w_au_sum[2*WIDTH-1:WIDTH];
            w_fix_lo = w_au_sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_PREP;
            S_PREP: begin
                busy   = 1'b1;
                w_next = flush ? S_IDLE : S_ITER;
            end
            S_ITER: begin
                busy = 1'b1;
                if (flush)               w_next = S_IDLE;
                else if (r_cnt == '0)    w_next = S_FIX;
            end
            S_FIX: begin
                busy   = 1'b1;
                w_next = flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = w_accept ? S_PREP : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op       <= '0;
            r_hi_w     <= '0;
            r_lo_w     <= '0;
            r_opnd     <= '0;
            r_cnt      <= '0;
            r_res_neg  <= 1'b0;
            r_rem_neg  <= 1'b0;
            r_dz_pend  <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_op       <= op;
                        r_lo_w     <= a;
                        r_opnd     <= b;
                        r_hi_w     <= '0;
                        r_dz_pend  <= op[1] && (b == '0);
                        r_div_zero <= 1'b0;
                    end
                end
                S_PREP: begin
                    // Divide-by-zero keeps the all-ones quotient unsigned.
                    r_res_neg <= (w_a_neg ^ w_b_neg) & ~r_dz_pend;
                    r_rem_neg <= w_a_neg;
                    r_hi_w    <= '0;
                    r_cnt     <= c_cnt_last;
                    if (w_is_div) begin
                        r_lo_w <= w_mag_a;
                        r_opnd <= w_mag_b;
                    end else begin
                        r_opnd <= w_mag_a;
                        r_lo_w <= w_mag_b;
                    end
                end
                S_ITER: begin
                    r_cnt <= r_cnt - c_cnt_one;
                    if (w_is_div) begin
                        if (w_au_cout) begin
                            r_hi_w <= w_au_sum[WIDTH-1:0];
                            r_lo_w <= {r_lo_w[WIDTH-2:0], 1'b1};
                        end else begin
                            r_hi_w <= w_rem_shift[WIDTH-1:0];
                            r_lo_w <= {r_lo_w[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_hi_w <= w_au_sum[WIDTH:1];
                        r_lo_w <= {w_au_sum[0], r_lo_w[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        r_hi       <= w_fix_hi;
                        r_lo       <= w_fix_lo;
                        r_div_zero <= r_dz_pend;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_div_zero;
endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_seq
// Description : Directed self-checking bench for muldiv_seq (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_muldiv_seq;
    localparam int c_lat = 34;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op    = 2'd0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[13];

    muldiv_seq #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input int limit, output int n, output logic busy_ok, output logic seen);
        n       = 0;
        busy_ok = 1'b1;
        seen    = 1'b0;
        while (!seen && n < limit) begin
            if (done) seen = 1'b1;
            else begin
                if (!busy) busy_ok = 1'b0;
                tick();
                n++;
            end
        end
    endtask

    initial begin
        int   n;
        int   t1;
        int   t2;
        int   dcount;
        logic bok;
        logic seen;

        vecs[0]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'd1, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
        vecs[2]  = '{2'd3, 32'hFFFFFFEF, 32'h00000005, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{2'd2, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4]  = '{2'd2, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6]  = '{2'd0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        vecs[7]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[8]  = '{2'd3, 32'd17,       32'hFFFFFFFB, 32'h00000002, 32'hFFFFFFFD, 1'b0};
        vecs[9]  = '{2'd3, 32'hFFFFEDCC, 32'h00000000, 32'hFFFFEDCC, 32'hFFFFFFFF, 1'b1};
        vecs[10] = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[11] = '{2'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[12] = '{2'd1, 32'h00000003, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};

        // Reset state
        #15;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset div_zero", {31'b0, div_zero}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; start = 1'b1;
            tick();
            start = 1'b0;
            wait_done(100, n, bok, seen);
            check($sformatf("v%0d done seen", i), {31'b0, seen}, 32'd1);
            check($sformatf("v%0d latency", i), n, c_lat);
            check($sformatf("v%0d busy held", i), {31'b0, bok}, 32'd1);
            check($sformatf("v%0d busy at done", i), {31'b0, busy}, 32'd0);
            check($sformatf("v%0d hi", i), hi, vecs[i].hi);
            check($sformatf("v%0d lo", i), lo, vecs[i].lo);
            check($sformatf("v%0d div_zero", i), {31'b0, div_zero}, {31'b0, vecs[i].dz});
            tick();
            check($sformatf("v%0d done pulse width", i), {31'b0, done}, 32'd0);
        end

        // start while busy is ignored
        op = 2'd0; a = 32'd5; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        op = 2'd2; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100, n, bok, seen);
        check("ignore start latency", 6 + n, c_lat);
        check("ignore start hi", hi, 32'd0);
        check("ignore start lo", lo, 32'd35);
        tick();

        // flush aborts, keeps prior results, no done
        op = 2'd0; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("flush busy before", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy after", {31'b0, busy}, 32'd0);
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) dcount++;
            tick();
        end
        check("flush no done/busy", dcount, 0);
        check("flush hi kept", hi, 32'd0);
        check("flush lo kept", lo, 32'd35);

        // asynchronous reset mid-DIV
        op = 2'd3; a = 32'hFFFFFFEF; b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check("pre-reset busy", {31'b0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async reset busy", {31'b0, busy}, 32'd0);
        check("async reset lo", lo, 32'd0);
        check("async reset hi", hi, 32'd0);
        check("async reset done", {31'b0, done}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) dcount++;
            tick();
        end
        check("no done after reset", dcount, 0);

        // back-to-back with start held through DONE
        op = 2'd2; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        wait_done(100, n, bok, seen);
        check("b2b first done", {31'b0, seen}, 32'd1);
        t1 = cyc;
        tick();
        check("b2b done falls", {31'b0, done}, 32'd0);
        check("b2b busy rises", {31'b0, busy}, 32'd1);
        wait_done(100, n, bok, seen);
        t2 = cyc;
        start = 1'b0;
        check("b2b second done", {31'b0, seen}, 32'd1);
        check("b2b spacing", t2 - t1, 35);
        check("b2b hi", hi, 32'd2);
        check("b2b lo", lo, 32'd14);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
